stack_op_sequencer: RTL

Multi-cycle controller that drives the 16-entry 8-bit LIFO stack. It turns single opcode requests into correctly ordered push/pop strobes. It latches operands from the stack's combinational top-of-stack output and pushes back ALU results. It tracks stack depth itself, because the stack exposes no empty/full flags, and rejects underflow and overflow before touching the stack. It sits between the CPU control unit and the stack.

---
 rtl/stack_op_sequencer_if.sv | 35 +++
 rtl/stack_op_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/stack_op_sequencer_if.sv
// stack_op_sequencer_if
// Groups the CPU-side request/response signals and the stack-side strobe/data
// signals of the stack operation sequencer.
//   master : CPU control unit plus stack (drives start/opcode/imm/stk_tos)
//   slave  : stack_op_sequencer (drives strobes, stk_din, status, result, depth)
// Parameters W (data width) and DEPTH (stack capacity) must match the sequencer.
interface stack_op_sequencer_if #(
    parameter int W     = 8,
    parameter int DEPTH = 16
);
    localparam int DW = $clog2(DEPTH) + 1;

    logic          start;
    logic [2:0]    opcode;
    logic [W-1:0]  imm;
    logic [W-1:0]  stk_tos;
    logic          stk_push;
    logic          stk_pop;
    logic [W-1:0]  stk_din;
    logic          busy;
    logic          done;
    logic          err;
    logic [W-1:0]  result;
    logic [DW-1:0] depth;

    modport master (
        output start, opcode, imm, stk_tos,
        input  stk_push, stk_pop, stk_din, busy, done, err, result, depth
    );

    modport slave (
        input  start, opcode, imm, stk_tos,
        output stk_push, stk_pop, stk_din, busy, done, err, result, depth
    );
endinterface

// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer
// Turns single opcode requests into ordered push/pop strobes for a LIFO stack
// that has a combinational top-of-stack output and no empty/full flags. The
// sequencer tracks the entry count itself and rejects under/overflow before
// any strobe is issued.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset (shared with the stack)
//   bus  - stack_op_sequencer_if.slave: start/opcode/imm/stk_tos in;
//          stk_push/stk_pop/stk_din/busy/done/err/result/depth out
// Build option: define STACK_SEQ_SWAP_EN to execute opcode 111 as SWAP;
// otherwise opcode 111 is rejected with err.
//
// state | meaning
// IDLE  | waiting for start; legality checked at accept
// POP1  | pop former top (a)
// POP2  | pop second entry (b), compute result
// PUSH1 | push result (or a for SWAP)
// PUSH2 | push b (SWAP only)
// DONE  | one-cycle completion, err reported here
module stack_op_sequencer #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input logic                  clk,
    input logic                  rst,
    stack_op_sequencer_if.slave  bus
);
    localparam int DW = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);
    localparam logic [DW-1:0] ONE     = DW'(1);
    localparam logic [DW-1:0] TWO     = DW'(2);

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_DUP  = 3'b110;
    localparam logic [2:0] OP_SWAP = 3'b111;

    typedef enum logic [2:0] {IDLE, POP1, POP2, PUSH1, PUSH2, DONE} state_t;

    state_t        state, state_nx;
    logic [2:0]    op_q;
    logic          err_q;
    logic [W-1:0]  a_q;
`ifdef STACK_SEQ_SWAP_EN
    logic [W-1:0]  b_q;
`endif
    logic [W-1:0]  din_q;
    logic [W-1:0]  result_q;
    logic [DW-1:0] depth_q;
    logic          legal;

    // b is the second-from-top entry, a the former top.
    function automatic logic [W-1:0] alu(input logic [2:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        case (op)
            OP_ADD:  return b + a;
            OP_SUB:  return b - a;
            OP_AND:  return b & a;
            OP_OR:   return b | a;
            default: return b;
        endcase
    endfunction

    always_comb begin
        legal = 1'b0;
        case (bus.opcode)
            OP_PUSH:                        legal = (depth_q < DEPTH_C);
            OP_POP:                         legal = (depth_q >= ONE);
            OP_ADD, OP_SUB, OP_AND, OP_OR:  legal = (depth_q >= TWO);
            OP_DUP:                         legal = (depth_q >= ONE) && (depth_q < DEPTH_C);
`ifdef STACK_SEQ_SWAP_EN
            OP_SWAP:                        legal = (depth_q >= TWO);
`endif
            default:                        legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (!legal)
                        state_nx = DONE;
                    else if (bus.opcode == OP_PUSH || bus.opcode == OP_DUP)
                        state_nx = PUSH1;
                    else
                        state_nx = POP1;
                end
            end
            POP1:  state_nx = (op_q == OP_POP) ? DONE : POP2;
            POP2:  state_nx = PUSH1;
`ifdef STACK_SEQ_SWAP_EN
            PUSH1: state_nx = (op_q == OP_SWAP) ? PUSH2 : DONE;
            PUSH2: state_nx = DONE;
`else
            PUSH1: state_nx = DONE;
`endif
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= OP_PUSH;
            err_q    <= 1'b0;
            a_q      <= '0;
`ifdef STACK_SEQ_SWAP_EN
            b_q      <= '0;
`endif
            din_q    <= '0;
            result_q <= '0;
            depth_q  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q  <= bus.opcode;
                        err_q <= !legal;
                        a_q   <= bus.stk_tos;
                        // PUSH/DUP go straight to PUSH1, so stk_din is loaded now.
                        if (legal && bus.opcode == OP_PUSH)
                            din_q <= bus.imm;
                        else if (legal && bus.opcode == OP_DUP)
                            din_q <= bus.stk_tos;
                    end
                end
                POP1: begin
                    a_q     <= bus.stk_tos;
                    depth_q <= depth_q - ONE;
                    if (op_q == OP_POP)
                        result_q <= bus.stk_tos;
                end
                POP2: begin
`ifdef STACK_SEQ_SWAP_EN
                    b_q <= bus.stk_tos;
`endif
                    depth_q <= depth_q - ONE;
                    din_q   <= (op_q == OP_SWAP) ? a_q : alu(op_q, a_q, bus.stk_tos);
                end
                PUSH1: begin
                    depth_q <= depth_q + ONE;
                    if (op_q != OP_SWAP)
                        result_q <= din_q;
`ifdef STACK_SEQ_SWAP_EN
                    else
                        din_q <= b_q;
`endif
                end
                PUSH2: depth_q <= depth_q + ONE;
                default: ;
            endcase
        end
    end

    assign bus.stk_pop  = (state == POP1) || (state == POP2);
    assign bus.stk_push = (state == PUSH1) || (state == PUSH2);
    assign bus.stk_din  = din_q;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.err      = (state == DONE) && err_q;
    assign bus.result   = result_q;
    assign bus.depth    = depth_q;
endmodule
